// File: rtl/prog_mem_loader_if.sv
// Byte-stream loader and CPU instruction-fetch signals for prog_mem_loader.
// The master modport is the side that feeds bytes and presents pc.
interface prog_mem_loader_if #(
    parameter int AW = 7,
    parameter int DW = 16
);
    logic          load_req;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW-1:0] pc;
    logic [DW-1:0] ins_out;
    logic          cpu_rst_n;
    logic [AW-1:0] load_addr;
    logic [AW:0]   loaded_words;
    logic          load_err;

    modport master (
        output load_req, ld_valid, ld_data, ld_last, pc,
        input  ld_ready, ins_out, cpu_rst_n, load_addr, loaded_words, load_err
    );

    modport slave (
        input  load_req, ld_valid, ld_data, ld_last, pc,
        output ld_ready, ins_out, cpu_rst_n, load_addr, loaded_words, load_err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with a byte-serial loader (high byte first per word).
// The CPU is held in reset until a load ends cleanly with ld_last on a low byte.
module prog_mem_loader #(
    parameter int            AW  = 7,
    parameter int            DW  = 16,
    parameter logic [DW-1:0] NOP = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    prog_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_load_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [AW:0]   r_loaded_words;
    logic [AW:0]   w_words_nxt;
    logic          r_load_err;
    logic          w_err_nxt;
    logic [7:0]    r_hi_byte;
    logic [7:0]    w_hi_nxt;
    logic          r_ld_ready;
    logic          r_cpu_rst_n;
    logic          w_we;
    logic          w_xfer;
    logic          w_hit;
    logic [DW-1:0] r_mem [0:(2**AW)-1];

    // Next-state and datapath update; load_req overrides anything in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_load_addr;
        w_words_nxt = r_loaded_words;
        w_err_nxt   = r_load_err;
        w_hi_nxt    = r_hi_byte;
        w_we        = 1'b0;
        w_xfer      = bus.ld_valid & r_ld_ready;
        if (bus.load_req) begin
            w_state_nxt = LOAD_HI;
            w_addr_nxt  = {AW{1'b0}};
            w_words_nxt = {(AW+1){1'b0}};
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                LOAD_HI: begin
                    if (w_xfer) begin
                        if (bus.ld_last) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_hi_nxt    = bus.ld_data;
                            w_state_nxt = LOAD_LO;
                        end
                    end else begin
                        w_state_nxt = LOAD_HI;
                    end
                end
                LOAD_LO: begin
                    if (w_xfer) begin
                        w_we        = 1'b1;
                        w_addr_nxt  = r_load_addr + {{(AW-1){1'b0}}, 1'b1};
                        w_words_nxt = r_loaded_words + {{AW{1'b0}}, 1'b1};
                        // A clean finish on the very last slot still wins over overflow.
                        if (bus.ld_last) begin
                            w_state_nxt = RUN;
                        end else if (r_load_addr == {AW{1'b1}}) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = LOAD_HI;
                        end
                    end else begin
                        w_state_nxt = LOAD_LO;
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and decoded handshake/reset outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_load_addr    <= {AW{1'b0}};
            r_loaded_words <= {(AW+1){1'b0}};
            r_load_err     <= 1'b0;
            r_hi_byte      <= 8'h00;
            r_ld_ready     <= 1'b0;
            r_cpu_rst_n    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_load_addr    <= w_addr_nxt;
            r_loaded_words <= w_words_nxt;
            r_load_err     <= w_err_nxt;
            r_hi_byte      <= w_hi_nxt;
            r_ld_ready     <= (w_state_nxt == LOAD_HI) || (w_state_nxt == LOAD_LO);
            r_cpu_rst_n    <= (w_state_nxt == RUN);
        end
    end

    // Program array write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[r_load_addr] <= {r_hi_byte, bus.ld_data};
        end
    end

    assign w_hit            = (r_state == RUN) && ({1'b0, bus.pc} < r_loaded_words);
    assign bus.ins_out      = w_hit ? r_mem[bus.pc] : NOP;
    assign bus.ld_ready     = r_ld_ready;
    assign bus.cpu_rst_n    = r_cpu_rst_n;
    assign bus.load_addr    = r_load_addr;
    assign bus.loaded_words = r_loaded_words;
    assign bus.load_err     = r_load_err;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader against a byte-list reference model.
module tb_prog_mem_loader;
    localparam int AW = 7;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.AW(AW), .DW(DW)) bus ();

    prog_mem_loader #(.AW(AW), .DW(DW), .NOP(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [128];
    logic [7:0]  tx [256];
    int exp_words, exp_addr, n_used;
    bit exp_err, exp_run, exp_loading;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
    endtask

    // Reference: walk the byte list applying the load rules word by word.
    task automatic model_load(input int n, input int last_idx);
        bit done;
        done = 1'b0;
        exp_words = 0; exp_addr = 0; exp_err = 1'b0; exp_run = 1'b0;
        exp_loading = 1'b1; n_used = n;
        for (int i = 0; i < n; i++) begin
            if (!done) begin
                if (i % 2 == 0) begin
                    if (i == last_idx) begin
                        exp_err = 1'b1; exp_loading = 1'b0; done = 1'b1; n_used = i + 1;
                    end
                end else begin
                    ref_mem[exp_addr] = {tx[i-1], tx[i]};
                    exp_words++;
                    exp_addr = (exp_addr + 1) % 128;
                    if (i == last_idx) begin
                        exp_run = 1'b1; exp_loading = 1'b0; done = 1'b1; n_used = i + 1;
                    end else if (exp_words == 128) begin
                        exp_err = 1'b1; exp_loading = 1'b0; done = 1'b1; n_used = i + 1;
                    end
                end
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random idles.
    task automatic send_bytes(input int cnt, input int last_idx, input int gap_mode);
        int gaps;
        for (int i = 0; i < cnt; i++) begin
            gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? $urandom_range(0, 2) : 0);
            for (int g = 0; g < gaps; g++) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'($urandom);
                bus.ld_last  = 1'b0;
                step();
                checks++;
                if (bus.ld_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_while_waiting byte=%0d got=%b want=1", i, bus.ld_ready);
                end
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = tx[i];
            bus.ld_last  = (i == last_idx);
            checks++;
            if (bus.ld_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready_on_byte byte=%0d got=%b want=1", i, bus.ld_ready);
            end
            step();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.pc = 7'd0;
        step();
        checks++;
        if (bus.ld_ready !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.ins_out !== 16'h0000 ||
            bus.loaded_words !== 8'd0 || bus.load_err !== 1'b0 || bus.load_addr !== 7'd0) begin
            failures++;
            $display("FAIL reset rdy=%b crn=%b ins=%h words=%0d err=%b addr=%0d want 0/0/0000/0/0/0",
                     bus.ld_ready, bus.cpu_rst_n, bus.ins_out, bus.loaded_words, bus.load_err, bus.load_addr);
        end
    endtask

    task automatic test_basic(input int gap_mode);
        pulse_load_req();
        checks++;
        if (bus.ld_ready !== 1'b1 || bus.load_addr !== 7'd0 || bus.cpu_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL basic_start rdy=%b addr=%0d crn=%b want 1/0/0", bus.ld_ready, bus.load_addr, bus.cpu_rst_n);
        end
        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56; tx[3] = 8'h78;
        model_load(4, 3);
        send_bytes(n_used, 3, gap_mode);
        checks++;
        if (bus.cpu_rst_n !== 1'b1 || bus.loaded_words !== 8'd2 || bus.load_err !== 1'b0 || bus.ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_done crn=%b words=%0d err=%b rdy=%b want 1/2/0/0",
                     bus.cpu_rst_n, bus.loaded_words, bus.load_err, bus.ld_ready);
        end
        for (int p = 0; p < 4; p++) begin
            bus.pc = 7'(p);
            #1;
            checks++;
            if (bus.ins_out !== ((p == 0) ? 16'h1234 : (p == 1) ? 16'h5678 : 16'h0000)) begin
                failures++;
                $display("FAIL basic_ins pc=%0d got=%h", p, bus.ins_out);
            end
        end
    endtask

    task automatic test_random();
        int n, last_idx, p;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 60);
            last_idx = ($urandom_range(0, 3) != 0) ? n - 1 : -1;
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            pulse_load_req();
            model_load(n, last_idx);
            send_bytes(n_used, last_idx, 2);
            checks++;
            if (bus.cpu_rst_n !== exp_run || bus.load_err !== exp_err || bus.ld_ready !== exp_loading ||
                bus.loaded_words !== 8'(exp_words) || bus.load_addr !== 7'(exp_addr)) begin
                failures++;
                $display("FAIL random_status it=%0d crn=%b/%b err=%b/%b rdy=%b/%b words=%0d/%0d addr=%0d/%0d",
                         it, bus.cpu_rst_n, exp_run, bus.load_err, exp_err, bus.ld_ready, exp_loading,
                         bus.loaded_words, exp_words, bus.load_addr, exp_addr);
            end
            for (int k = 0; k < 12; k++) begin
                p = (k == 0) ? exp_words % 128 : $urandom_range(0, 40);
                bus.pc = 7'(p);
                #1;
                checks++;
                if (bus.ins_out !== ((exp_run && p < exp_words) ? ref_mem[p] : 16'h0000)) begin
                    failures++;
                    $display("FAIL random_ins it=%0d pc=%0d got=%h want=%h", it, p, bus.ins_out,
                             (exp_run && p < exp_words) ? ref_mem[p] : 16'h0000);
                end
            end
        end
    endtask

    task automatic test_odd_length();
        int bad;
        pulse_load_req();
        tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC;
        model_load(3, 2);
        send_bytes(n_used, 2, 0);
        checks++;
        if (bus.load_err !== 1'b1 || bus.cpu_rst_n !== 1'b0 || bus.loaded_words !== 8'd1 || bus.ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL odd_status err=%b crn=%b words=%0d rdy=%b want 1/0/1/0",
                     bus.load_err, bus.cpu_rst_n, bus.loaded_words, bus.ld_ready);
        end
        bad = 0;
        for (int p = 0; p < 128; p++) begin
            bus.pc = 7'(p);
            #1;
            if (bus.ins_out !== 16'h0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL odd_ins_nop nonzero_pcs=%0d want 0", bad);
        end
    endtask

    task automatic test_overflow(input bit with_last);
        int bad, last_idx;
        last_idx = with_last ? 255 : -1;
        for (int i = 0; i < 256; i++) tx[i] = 8'($urandom);
        pulse_load_req();
        model_load(256, last_idx);
        send_bytes(n_used, last_idx, 0);
        checks++;
        if (bus.load_err !== exp_err || bus.cpu_rst_n !== exp_run || bus.loaded_words !== 8'd128 ||
            bus.load_addr !== 7'd0 || bus.ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL overflow_status last=%b err=%b/%b crn=%b/%b words=%0d addr=%0d rdy=%b",
                     with_last, bus.load_err, exp_err, bus.cpu_rst_n, exp_run, bus.loaded_words,
                     bus.load_addr, bus.ld_ready);
        end
        bad = 0;
        for (int p = 0; p < 128; p++) begin
            bus.pc = 7'(p);
            #1;
            if (bus.ins_out !== (exp_run ? ref_mem[p] : 16'h0000)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL overflow_ins last=%b wrong_pcs=%0d want 0", with_last, bad);
        end
    endtask

    task automatic test_reload();
        bus.load_req = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hEE;
        step();
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
        checks++;
        if (bus.cpu_rst_n !== 1'b0 || bus.load_addr !== 7'd0 || bus.loaded_words !== 8'd0 ||
            bus.load_err !== 1'b0 || bus.ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL reload_start crn=%b addr=%0d words=%0d err=%b rdy=%b want 0/0/0/0/1",
                     bus.cpu_rst_n, bus.load_addr, bus.loaded_words, bus.load_err, bus.ld_ready);
        end
        tx[0] = 8'h01; tx[1] = 8'h02;
        model_load(2, 1);
        send_bytes(n_used, 1, 0);
        bus.pc = 7'd0;
        #1;
        checks++;
        if (bus.ins_out !== 16'h0102 || bus.cpu_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL reload_word0 got=%h crn=%b want 0102/1", bus.ins_out, bus.cpu_rst_n);
        end
        bus.pc = 7'd1;
        #1;
        checks++;
        if (bus.ins_out !== 16'h0000) begin
            failures++;
            $display("FAIL reload_beyond got=%h want 0000", bus.ins_out);
        end
    endtask

    task automatic test_rst_mid_load();
        for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
        pulse_load_req();
        model_load(5, -1);
        send_bytes(n_used, -1, 0);
        rst = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h5A;
        step();
        rst = 1'b0;
        bus.ld_valid = 1'b0;
        step();
        checks++;
        if (bus.ld_ready !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.loaded_words !== 8'd0 ||
            bus.load_addr !== 7'd0 || bus.load_err !== 1'b0 || bus.ins_out !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid rdy=%b crn=%b words=%0d addr=%0d err=%b ins=%h want 0/0/0/0/0/0000",
                     bus.ld_ready, bus.cpu_rst_n, bus.loaded_words, bus.load_addr, bus.load_err, bus.ins_out);
        end
    endtask

    initial begin
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        bus.ld_last  = 1'b0;
        bus.pc       = 7'd0;
        test_reset();
        test_basic(0);
        test_basic(1);
        test_odd_length();
        test_random();
        test_overflow(1'b0);
        test_overflow(1'b1);
        test_reload();
        test_rst_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
